// File: rtl/weight_decode_reader.sv
// Reads the compensation slots and reduced weights of one array column,
// rebuilds the 8-bit weights and streams them out row by row.
`timescale 1ns/1ps
module weight_decode_reader #(
  parameter int SIZE            = 8,
  parameter int MEM_SIZE        = SIZE * SIZE,
  parameter int ADDR_WIDTH      = $clog2(MEM_SIZE),
  parameter int CROW_WIDTH      = $clog2(SIZE),
  parameter int CMEM_SIZE       = SIZE * 3,
  parameter int CMEM_ADDR_WIDTH = $clog2(CMEM_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CROW_WIDTH-1:0]      col,
  output logic                       busy,
  output logic                       wmem_rd_en,
  output logic [ADDR_WIDTH-1:0]      wmem_addr,
  input  logic [4:0]                 wmem_rdata,
  output logic                       cmem_rd_en,
  output logic [CMEM_ADDR_WIDTH-1:0] cmem_addr,
  input  logic [7:0]                 cmem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_weight,
  output logic [CROW_WIDTH-1:0]      out_row,
  output logic                       out_comp_hit,
  output logic                       done,
  output logic                       decode_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    C_RD  = 3'd1,
    C_CAP = 3'd2,
    W_RD  = 3'd3,
    W_CAP = 3'd4,
    W_OUT = 3'd5
  } state_t;

  state_t                 state;
  logic [CROW_WIDTH-1:0]  col_reg;
  logic [CROW_WIDTH-1:0]  row_reg;
  logic [1:0]             k_reg;
  // Slot layout: {valid, row[2:0], cw[2:0]}; the cw sign copy is never used.
  logic [6:0]             slot_reg [3];

  logic                   unused_cw_sign;
  assign unused_cw_sign = cmem_rdata[3];

  assign busy = (state != IDLE);

  // Address bases at full width so col*SIZE+row never wraps for col < SIZE.
  logic [ADDR_WIDTH-1:0]      w_base;
  logic [CMEM_ADDR_WIDTH-1:0] c_base;
  logic [CMEM_ADDR_WIDTH-1:0] c_base_in;
  logic [CROW_WIDTH-1:0]      row_inc;
  logic [1:0]                 k_inc;

  assign w_base    = ADDR_WIDTH'(col_reg) * ADDR_WIDTH'(SIZE);
  assign c_base    = CMEM_ADDR_WIDTH'(col_reg) * CMEM_ADDR_WIDTH'(3);
  assign c_base_in = CMEM_ADDR_WIDTH'(col) * CMEM_ADDR_WIDTH'(3);
  assign row_inc   = row_reg + 1'b1;
  assign k_inc     = k_reg + 2'd1;

  logic [2:0] slot_match;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_match
      assign slot_match[gi] = slot_reg[gi][6] &&
                              (CROW_WIDTH'(slot_reg[gi][5:3]) == row_reg);
    end
  endgenerate

  logic       any_match;
  logic [2:0] sel_cw;
  logic       flag;
  logic [3:0] red;
  logic [7:0] dec_weight;
  logic       dec_hit;
  logic       dec_err;

  assign any_match = |slot_match;
  assign flag      = wmem_rdata[4];
  assign red       = wmem_rdata[3:0];
  assign dec_err   = !flag && any_match;

  always_comb begin
    sel_cw = 3'b000;
    if (slot_match[0])
      sel_cw = slot_reg[0][2:0];
    else if (slot_match[1])
      sel_cw = slot_reg[1][2:0];
    else if (slot_match[2])
      sel_cw = slot_reg[2][2:0];
  end

  always_comb begin
    dec_weight = {{3{red[3]}}, red, 1'b0};
    dec_hit    = 1'b0;
    if (flag) begin
      if (any_match) begin
        dec_weight = {red, sel_cw, 1'b0};
        dec_hit    = 1'b1;
      end else begin
        dec_weight = {red, 4'b0000};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      col_reg      <= '0;
      row_reg      <= '0;
      k_reg        <= '0;
      for (int j = 0; j < 3; j++) slot_reg[j] <= '0;
      wmem_rd_en   <= 1'b0;
      wmem_addr    <= '0;
      cmem_rd_en   <= 1'b0;
      cmem_addr    <= '0;
      out_valid    <= 1'b0;
      out_weight   <= '0;
      out_row      <= '0;
      out_comp_hit <= 1'b0;
      done         <= 1'b0;
      decode_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            col_reg    <= col;
            k_reg      <= '0;
            for (int j = 0; j < 3; j++) slot_reg[j] <= '0;
            cmem_rd_en <= 1'b1;
            cmem_addr  <= c_base_in;
            state      <= C_RD;
          end
        end
        C_RD: begin
          cmem_rd_en <= 1'b0;
          state      <= C_CAP;
        end
        C_CAP: begin
          for (int j = 0; j < 3; j++)
            if (k_reg == 2'(j)) slot_reg[j] <= {cmem_rdata[7:4], cmem_rdata[2:0]};
          if (k_reg == 2'd2) begin
            row_reg    <= '0;
            wmem_rd_en <= 1'b1;
            wmem_addr  <= w_base;
            state      <= W_RD;
          end else begin
            k_reg      <= k_inc;
            cmem_rd_en <= 1'b1;
            cmem_addr  <= c_base + CMEM_ADDR_WIDTH'(k_inc);
            state      <= C_RD;
          end
        end
        W_RD: begin
          wmem_rd_en <= 1'b0;
          state      <= W_CAP;
        end
        W_CAP: begin
          out_weight   <= dec_weight;
          out_row      <= row_reg;
          out_comp_hit <= dec_hit;
          out_valid    <= 1'b1;
          if (dec_err) decode_err <= 1'b1;
          state        <= W_OUT;
        end
        W_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (row_reg == CROW_WIDTH'(SIZE - 1)) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              row_reg    <= row_inc;
              wmem_rd_en <= 1'b1;
              wmem_addr  <= w_base + ADDR_WIDTH'(row_inc);
              state      <= W_RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
